// File: rtl/pcieifc_mc_sync_fifo.sv
// Multi-channel sync FIFO: one shared memory split into CHNL_NUM circular queues.
// Latency: write visible next cycle; read data registered, one cycle after rd_en.
// Backpressure: none; writes to full / reads from empty are dropped and flagged sticky.
module pcieifc_mc_sync_fifo #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int CHNLSIZE     = 2,
    parameter int AFULL_THRESH = 12,
    localparam int CHNL_NUM    = 1 << CHNLSIZE,
    localparam int CW          = ADDRSIZE + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CHNLSIZE-1:0]      wr_chnl,
    input  logic [DATASIZE-1:0]      wdata,
    input  logic                     rd_en,
    input  logic [CHNLSIZE-1:0]      rd_chnl,
    output logic [DATASIZE-1:0]      rdata,
    output logic                     rvalid,
    output logic [CHNL_NUM-1:0]      full,
    output logic [CHNL_NUM-1:0]      empty,
    output logic [CHNL_NUM-1:0]      afull,
    output logic [CHNL_NUM*CW-1:0]   count,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int MEM_WORDS          = CHNL_NUM << ADDRSIZE;
    localparam logic [CW-1:0] PTR_ONE  = CW'(1);
    localparam logic [CW-1:0] DEPTH_LV = CW'(1 << ADDRSIZE);
    localparam logic [CW-1:0] AFULL_LV = CW'(AFULL_THRESH);

    logic [DATASIZE-1:0] mem [MEM_WORDS];

    logic [CHNL_NUM-1:0][CW-1:0] wptr_q, wptr_d;
    logic [CHNL_NUM-1:0][CW-1:0] rptr_q, rptr_d;
    logic [CHNL_NUM-1:0][CW-1:0] cnt;
    logic [DATASIZE-1:0]         rdata_q, rdata_d;
    logic                        rvalid_q, rvalid_d;
    logic                        ovf_q, ovf_d;
    logic                        udf_q, udf_d;

    logic                         wr_acc, rd_acc;
    logic [CHNLSIZE+ADDRSIZE-1:0] waddr, raddr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        cnt   = '0;
        full  = '0;
        empty = '0;
        afull = '0;
        count = '0;
        for (int c = 0; c < CHNL_NUM; c++) begin
            cnt[c]            = wptr_q[c] - rptr_q[c];
            full[c]           = (cnt[c] == DEPTH_LV);
            empty[c]          = (cnt[c] == '0);
            afull[c]          = (cnt[c] >= AFULL_LV);
            count[c*CW +: CW] = cnt[c];
        end
    end

    assign wr_acc = wr_en && !full[wr_chnl];
    assign rd_acc = rd_en && !empty[rd_chnl];
    assign waddr  = {wr_chnl, wptr_q[wr_chnl][ADDRSIZE-1:0]};
    assign raddr  = {rd_chnl, rptr_q[rd_chnl][ADDRSIZE-1:0]};

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q || (wr_en && full[wr_chnl]);
        udf_d    = udf_q || (rd_en && empty[rd_chnl]);
        if (wr_acc) begin
            wptr_d[wr_chnl] = wptr_q[wr_chnl] + PTR_ONE;
        end
        // No bypass: a read of an empty channel misses even if it is written this cycle.
        if (rd_acc) begin
            rptr_d[rd_chnl] = rptr_q[rd_chnl] + PTR_ONE;
            rdata_d         = mem[raddr];
            rvalid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately unreset; reads only ever target written slots.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule
